// File: rtl/adc_scan_seq_if.sv
// ADC scan sequencer bus: conversion handshake to the ADC macro and the
// averaged-result valid/ready stream toward the consumer.
interface adc_scan_seq_if #(
   parameter int unsigned DW = 12
);
   logic          adc_soc;
   logic [2:0]    adc_sel;
   logic          adc_eoc;
   logic [DW-1:0] adc_dout;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [2:0]    out_ch;

   modport master (
      output adc_soc, adc_sel, out_valid, out_data, out_ch,
      input  adc_eoc, adc_dout, out_ready
   );

   modport slave (
      input  adc_soc, adc_sel, out_valid, out_data, out_ch,
      output adc_eoc, adc_dout, out_ready
   );
endinterface

// File: rtl/adc_scan_seq.sv
// Multi-channel ADC scan sequencer: scans the enabled channels, averages
// 2^AVG_LOG2 conversions per channel and streams (channel, average) results.
module adc_scan_seq #(
   parameter int unsigned CH_NUM     = 8,
   parameter int unsigned DW         = 12,
   parameter int unsigned AVG_LOG2   = 2,
   parameter int unsigned SOC_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              cont,
   input  logic [CH_NUM-1:0] ch_mask,
   input  logic              err_clr,
   output logic              busy,
   output logic              timeout_err,
   adc_scan_seq_if.master    bus
);
   localparam int unsigned AW = DW + AVG_LOG2;
   localparam int unsigned CW = AVG_LOG2 + 1;
   localparam int unsigned SW = (SOC_CYCLES > 1) ? $clog2(SOC_CYCLES) : 1;
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [CW-1:0] AVG_N    = CW'(2 ** AVG_LOG2);
   localparam logic [SW-1:0] SOC_LAST = SW'(SOC_CYCLES - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, SOC, WAIT, OUT, NEXT} state_t;

   state_t            state;
   logic [CH_NUM-1:0] mask_q;
   logic [2:0]        ch;
   logic [AW-1:0]     acc;
   logic [CW-1:0]     cnt;
   logic [SW-1:0]     soc_cnt;
   logic [TW-1:0]     tmo_cnt;
   logic              eoc_q;
   logic              soc_q;
   logic              out_valid_q;
   logic [DW-1:0]     out_data_q;
   logic [2:0]        out_ch_q;

   logic [2:0]        first_ch_c;
   logic              first_ok_c;
   logic [2:0]        next_ch_c;
   logic              next_ok_c;
   logic              eoc_edge_c;
   logic [AW-1:0]     acc_sum_c;
   logic [CW-1:0]     cnt_inc_c;

   assign bus.adc_soc   = soc_q;
   assign bus.adc_sel   = ch;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ch    = out_ch_q;

   assign eoc_edge_c = bus.adc_eoc & ~eoc_q;
   assign acc_sum_c  = acc + AW'(bus.adc_dout);
   assign cnt_inc_c  = cnt + CW'(1);

   // Lowest enabled channel of the live mask (scan start / wrap) and the next
   // higher enabled channel of the latched mask (advance within a scan).
   always_comb begin
      first_ch_c = '0;
      first_ok_c = 1'b0;
      next_ch_c  = '0;
      next_ok_c  = 1'b0;
      for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            first_ch_c = 3'(i);
            first_ok_c = 1'b1;
         end
         if (mask_q[i] && (i > int'(ch))) begin
            next_ch_c = 3'(i);
            next_ok_c = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mask_q      <= '0;
         ch          <= '0;
         acc         <= '0;
         cnt         <= '0;
         soc_cnt     <= '0;
         tmo_cnt     <= '0;
         eoc_q       <= 1'b0;
         soc_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         eoc_q <= bus.adc_eoc;
         // A timeout set later in this block overrides a same-cycle clear.
         if (err_clr) timeout_err <= 1'b0;

         unique case (state)
            IDLE: begin
               if (start && first_ok_c) begin
                  mask_q  <= ch_mask;
                  ch      <= first_ch_c;
                  soc_cnt <= '0;
                  soc_q   <= 1'b1;
                  busy    <= 1'b1;
                  state   <= SOC;
               end
            end

            SOC: begin
               if (soc_cnt == SOC_LAST) begin
                  soc_q   <= 1'b0;
                  tmo_cnt <= '0;
                  state   <= WAIT;
               end else begin
                  soc_cnt <= soc_cnt + SW'(1);
               end
            end

            WAIT: begin
               if (eoc_edge_c) begin
                  if (cnt_inc_c == AVG_N) begin
                     out_data_q  <= DW'(acc_sum_c >> AVG_LOG2);
                     out_ch_q    <= ch;
                     out_valid_q <= 1'b1;
                     state       <= OUT;
                  end else begin
                     acc     <= acc_sum_c;
                     cnt     <= cnt_inc_c;
                     soc_cnt <= '0;
                     soc_q   <= 1'b1;
                     state   <= SOC;
                  end
               end else if (tmo_cnt == TMO_LAST) begin
                  timeout_err <= 1'b1;
                  state       <= NEXT;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= NEXT;
               end
            end

            NEXT: begin
               acc <= '0;
               cnt <= '0;
               if (next_ok_c) begin
                  ch      <= next_ch_c;
                  soc_cnt <= '0;
                  soc_q   <= 1'b1;
                  state   <= SOC;
               end else if (cont && first_ok_c) begin
                  // Continuous wrap re-latches the live mask.
                  mask_q  <= ch_mask;
                  ch      <= first_ch_c;
                  soc_cnt <= '0;
                  soc_q   <= 1'b1;
                  state   <= SOC;
               end else begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_scan_seq.sv
// Bench for adc_scan_seq: randomized ADC responder feeding a scoreboard of
// expected per-channel averages, checked by an independent output monitor.
module tb_adc_scan_seq;
   localparam int unsigned CH_NUM     = 8;
   localparam int unsigned DW         = 12;
   localparam int unsigned AVG_LOG2   = 2;
   localparam int unsigned SOC_CYCLES = 2;
   localparam int unsigned TIMEOUT    = 16;

   typedef struct {
      int ch;
      int data;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        cont = 1'b0;
   logic [7:0]  ch_mask = '0;
   logic        err_clr = 1'b0;
   logic        busy;
   logic        timeout_err;

   int          checks = 0;
   int          errors = 0;
   item_t       exp_q[$];
   item_t       smp_q[$];
   logic [7:0]  hang_mask = '0;
   int          ready_mode = 1;

   adc_scan_seq_if #(.DW(DW)) bus ();

   adc_scan_seq #(
      .CH_NUM(CH_NUM), .DW(DW), .AVG_LOG2(AVG_LOG2),
      .SOC_CYCLES(SOC_CYCLES), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .cont(cont), .ch_mask(ch_mask),
      .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One channel visit: four conversions whose truncated mean is the result.
   task automatic plan_visit(input int c, input int d0, input int d1, input int d2, input int d3);
      item_t s;
      item_t e;
      s.ch = c;
      s.data = d0; smp_q.push_back(s);
      s.data = d1; smp_q.push_back(s);
      s.data = d2; smp_q.push_back(s);
      s.data = d3; smp_q.push_back(s);
      e.ch   = c;
      e.data = (d0 + d1 + d2 + d3) / 4;
      exp_q.push_back(e);
   endtask

   task automatic plan_scan(input logic [7:0] m);
      for (int i = 0; i < 8; i++)
         if (m[i] && !hang_mask[i])
            plan_visit(i, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                       int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
   endtask

   task automatic pulse_start(input logic [7:0] m);
      ch_mask = m;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n;
      n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         tick();
         n++;
      end
      check(name, int'(n < budget), 1);
   endtask

   // Consumer ready: 0 forced low, 1 forced high, otherwise random.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // ADC macro model: answers each soc pulse after a random latency with the
   // next planned sample; hung channels never answer; spurious eoc during soc.
   bit    prev_soc = 1'b0;
   bit    pending = 1'b0;
   bit    hang = 1'b0;
   int    soc_len = 0;
   int    dly = 0;
   initial begin
      item_t s;
      bus.adc_eoc  = 1'b0;
      bus.adc_dout = '0;
      forever begin
         tick();
         bus.adc_eoc = 1'b0;
         if (rst) begin
            prev_soc = 1'b0;
            pending  = 1'b0;
            soc_len  = 0;
         end else begin
            if (pending) begin
               if (dly == 0) begin
                  pending = 1'b0;
                  if (smp_q.size() != 0) begin
                     s = smp_q.pop_front();
                     bus.adc_eoc  = 1'b1;
                     bus.adc_dout = 12'(s.data);
                  end
               end else begin
                  dly--;
               end
            end
            if (bus.adc_soc) begin
               if (!prev_soc) begin
                  soc_len = 0;
                  hang = hang_mask[bus.adc_sel];
                  if (!hang) begin
                     if (smp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL adc_sel: unexpected conversion on ch %0d", bus.adc_sel);
                     end else begin
                        check("adc_sel", int'(bus.adc_sel), smp_q[0].ch);
                     end
                  end
                  if ($urandom_range(0, 3) == 0) begin
                     bus.adc_eoc  = 1'b1;
                     bus.adc_dout = 12'($urandom);
                  end
               end
               soc_len++;
            end else if (prev_soc) begin
               check("soc_width", soc_len, SOC_CYCLES);
               if (!hang) begin
                  pending = 1'b1;
                  dly = int'($urandom_range(0, 5));
               end
            end
            prev_soc = bus.adc_soc;
         end
      end
   end

   // Output monitor: scoreboard pops, hold stability, no soc while presenting.
   bit         prev_hold = 1'b0;
   logic [11:0] prev_data = '0;
   logic [2:0]  prev_ch = '0;
   always @(negedge clk) begin : mon
      item_t e;
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (bus.out_valid) begin
            check("soc_during_out", int'(bus.adc_soc), 0);
            if (prev_hold) begin
               check("hold_data", int'(bus.out_data), int'(prev_data));
               check("hold_ch", int'(bus.out_ch), int'(prev_ch));
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_out: ch %0d data %0d with nothing expected",
                        bus.out_ch, bus.out_data);
            end else begin
               e = exp_q.pop_front();
               check("out_ch", int'(bus.out_ch), e.ch);
               check("out_data", int'(bus.out_data), e.data);
            end
         end
         prev_hold = bus.out_valid && !bus.out_ready;
         prev_data = bus.out_data;
         prev_ch   = bus.out_ch;
      end
   end

   task automatic run_timeout(input bit hold_clr);
      int n;
      hang_mask = 8'h02;
      ready_mode = 1;
      plan_scan(8'h03);
      err_clr = hold_clr;
      check("err_before_timeout", int'(timeout_err), 0);
      pulse_start(8'h03);
      n = 0;
      while (!(bus.adc_soc && bus.adc_sel == 3'd1) && n < 500) begin tick(); n++; end
      check("reach_ch1", int'(n < 500), 1);
      n = 0;
      while (bus.adc_soc && n < 10) begin tick(); n++; end
      n = 0;
      while (!timeout_err && n < 40) begin tick(); n++; end
      check("timeout_cycles", n, TIMEOUT);
      wait_done(500, "done_timeout");
      if (hold_clr) begin
         tick();
         check("err_cleared_held", int'(timeout_err), 0);
      end else begin
         check("err_sticky", int'(timeout_err), 1);
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         check("err_clr_pulse", int'(timeout_err), 0);
      end
      err_clr = 1'b0;
      hang_mask = '0;
   endtask

   initial begin : main
      int n;
      int soc_seen;
      logic [7:0] m;

      repeat (3) tick();
      check("rst_soc", int'(bus.adc_soc), 0);
      check("rst_sel", int'(bus.adc_sel), 0);
      check("rst_valid", int'(bus.out_valid), 0);
      check("rst_data", int'(bus.out_data), 0);
      check("rst_ch", int'(bus.out_ch), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_err", int'(timeout_err), 0);
      rst = 1'b0;
      tick();

      // Directed averages and soc timing; start/mask changes while busy ignored.
      plan_visit(0, 100, 101, 102, 103);
      plan_visit(2, 4000, 4000, 4000, 4000);
      pulse_start(8'h05);
      check("soc_cycle1", int'(bus.adc_soc), 1);
      check("sel_cycle1", int'(bus.adc_sel), 0);
      check("busy_cycle1", int'(busy), 1);
      tick();
      check("soc_cycle2", int'(bus.adc_soc), 1);
      tick();
      check("soc_cycle3", int'(bus.adc_soc), 0);
      pulse_start(8'hFF);
      wait_done(2000, "done_directed");
      repeat (3) tick();
      check("idle_after_directed", int'(busy), 0);

      pulse_start(8'h00);
      tick();
      check("mask0_ignored", int'(busy), 0);

      // Backpressure on the first result.
      ready_mode = 0;
      plan_scan(8'h03);
      pulse_start(8'h03);
      n = 0;
      while (!bus.out_valid && n < 500) begin tick(); n++; end
      check("bp_first_valid", int'(bus.out_valid), 1);
      soc_seen = 0;
      repeat (50) begin
         tick();
         if (bus.adc_soc) soc_seen++;
      end
      check("bp_no_soc", soc_seen, 0);
      check("bp_still_valid", int'(bus.out_valid), 1);
      ready_mode = 1;
      tick();
      check("bp_accepted", int'(bus.out_valid), 0);
      tick();
      check("bp_resume_soc", int'(bus.adc_soc), 1);
      check("bp_resume_sel", int'(bus.adc_sel), 1);
      wait_done(1000, "done_bp");

      run_timeout(1'b1);
      run_timeout(1'b0);

      // Continuous scanning, cont dropped during the third ch0 visit.
      ready_mode = 2;
      cont = 1'b1;
      for (int r = 0; r < 3; r++) plan_scan(8'h81);
      pulse_start(8'h81);
      n = 0;
      while (!(exp_q.size() == 2 && bus.adc_soc && bus.adc_sel == 3'd0) && n < 4000) begin
         tick(); n++;
      end
      check("cont_round3", int'(n < 4000), 1);
      cont = 1'b0;
      wait_done(2000, "done_cont");
      repeat (3) tick();
      check("cont_idle", int'(busy), 0);

      // Random masks with random backpressure; live mask scrambled mid-scan.
      for (int k = 0; k < 6; k++) begin
         m = 8'($urandom_range(1, 255));
         plan_scan(m);
         pulse_start(m);
         ch_mask = 8'($urandom);
         wait_done(4000, "done_random");
      end

      // Asynchronous reset while waiting on ch2's conversion.
      ready_mode = 1;
      plan_scan(8'h1F);
      pulse_start(8'h1F);
      n = 0;
      while (!(bus.adc_soc && bus.adc_sel == 3'd2) && n < 1000) begin tick(); n++; end
      while (bus.adc_soc && n < 1010) begin tick(); n++; end
      check("reach_wait_ch2", int'(n < 1010), 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("arst_soc", int'(bus.adc_soc), 0);
      check("arst_sel", int'(bus.adc_sel), 0);
      check("arst_valid", int'(bus.out_valid), 0);
      check("arst_data", int'(bus.out_data), 0);
      check("arst_ch", int'(bus.out_ch), 0);
      check("arst_busy", int'(busy), 0);
      tick();
      tick();
      exp_q.delete();
      smp_q.delete();
      rst = 1'b0;
      repeat (40) tick();
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_valid", int'(bus.out_valid), 0);
      plan_scan(8'h04);
      pulse_start(8'h04);
      check("post_rst_soc", int'(bus.adc_soc), 1);
      check("post_rst_sel", int'(bus.adc_sel), 2);
      wait_done(1000, "done_post_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1, "watchdog");
   end
endmodule
